paper_sequencer: RTL and testbench

Instruction sequencer for the 2-bit paper processor. Fetches instructions from program memory, decodes them, and drives the register file. It time-shares the single incrementer datapath between register INC/DEC and program-counter advance, so only one adder exists in the processor. It sits between program memory, the register file and the incrementer, and replaces the free-running pulse stepping with a clocked fetch/execute state machine.

---
 rtl/paper_sequencer.sv | 155 +++++++++++++++
 tb/tb_paper_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paper_sequencer.sv
// Fetch/execute sequencer for the 2-bit paper processor; one incrementer is shared
// between register INC/DEC and PC advance. Optional macro: SINGLE_STEP_EN.
module paper_sequencer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         step,
    output logic [W-1:0] imem_addr,
    input  logic [W+1:0] imem_data,
    output logic [W-1:0] reg_sel,
    input  logic [W-1:0] reg_rdata,
    output logic [W-1:0] reg_wdata,
    output logic         reg_we,
    output logic         inc_en,
    output logic [W-1:0] inc_a,
    input  logic [W-1:0] inc_sum,
    input  logic         inc_carry,
    output logic [W-1:0] pc,
    output logic         busy,
    output logic         halted,
    output logic         overflow
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, PCINC, HALT} state_t;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_ISZ = 2'b10;

    state_t       state, state_next;
    logic [W+1:0] ir, ir_next;
    logic [W-1:0] pc_next;
    logic         skip, skip_next;
    logic         ovf_next;
    logic [1:0]   opcode;
    logic [W-1:0] operand;
    logic         start;
    logic         continue_run;

    assign opcode  = ir[W+1:W];
    assign operand = ir[W-1:0];

`ifdef SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk) begin
        if (reset) step_q <= 1'b0;
        else       step_q <= step;
    end

    // Only a fresh step edge seen while idle launches one instruction.
    assign start        = run && step && !step_q;
    assign continue_run = 1'b0;
`else
    logic step_unused;

    assign step_unused  = step;
    assign start        = run;
    assign continue_run = run;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        skip_next  = skip;
        ovf_next   = overflow;
        imem_addr  = '0;
        reg_sel    = '0;
        reg_wdata  = '0;
        reg_we     = 1'b0;
        inc_en     = 1'b0;
        inc_a      = '0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                imem_addr  = pc;
                ir_next    = imem_data;
                state_next = EXEC;
            end
            EXEC: begin
                busy    = 1'b1;
                reg_sel = operand;
                case (opcode)
                    OP_INC: begin
                        inc_en     = 1'b1;
                        inc_a      = reg_rdata;
                        reg_wdata  = inc_sum;
                        // A reset arriving mid-EXEC must suppress the write.
                        reg_we     = !reset;
                        ovf_next   = overflow | inc_carry;
                        state_next = PCINC;
                    end
                    OP_DEC: begin
                        // Decrement as ~(~x + 1) so the single incrementer serves both.
                        inc_en     = 1'b1;
                        inc_a      = ~reg_rdata;
                        reg_wdata  = ~inc_sum;
                        reg_we     = !reset;
                        ovf_next   = overflow | inc_carry;
                        state_next = PCINC;
                    end
                    OP_ISZ: begin
                        skip_next  = (reg_rdata == '0);
                        state_next = PCINC;
                    end
                    default: begin
                        if (operand == pc) begin
                            state_next = HALT;
                        end else begin
                            pc_next    = operand;
                            state_next = continue_run ? FETCH : IDLE;
                        end
                    end
                endcase
            end
            PCINC: begin
                busy    = 1'b1;
                inc_en  = 1'b1;
                inc_a   = pc;
                pc_next = inc_sum;
                if (skip) skip_next  = 1'b0;
                else      state_next = continue_run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            skip     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            ir       <= ir_next;
            skip     <= skip_next;
            overflow <= ovf_next;
        end
    end
endmodule

// File: tb/tb_paper_sequencer.sv
// Scoreboard bench for paper_sequencer: an instruction-level reference model predicts
// register writes, pc changes, overflow and halt with their cycle numbers.
module tb_paper_sequencer;
    localparam int W = 2;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic [W-1:0] imem_addr;
    logic [W+1:0] imem_data;
    logic [W-1:0] reg_sel;
    logic [W-1:0] reg_rdata;
    logic [W-1:0] reg_wdata;
    logic         reg_we;
    logic         inc_en;
    logic [W-1:0] inc_a;
    logic [W-1:0] inc_sum;
    logic         inc_carry;
    logic [W-1:0] pc;
    logic         busy;
    logic         halted;
    logic         overflow;

    logic [W+1:0] imem [N];
    logic [W-1:0] regs [N];
    logic [W-1:0] init_regs [N];
    int           cyc = 0;

    typedef struct { int cyc; int a; int b; } ev_t;
    typedef struct { int code; int exp; } dchk_t;
    ev_t   wq[$];
    ev_t   pq[$];
    ev_t   oq[$];
    ev_t   hq[$];
    dchk_t dq[$];
    int    errors = 0;
    int    checks = 0;
    logic  mon_en = 1'b0;
    logic [W-1:0] last_pc = '0;
    logic  last_ovf = 1'b0;
    logic  last_halt = 1'b0;

    paper_sequencer #(.W(W)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .inc_en(inc_en), .inc_a(inc_a), .inc_sum(inc_sum), .inc_carry(inc_carry),
        .pc(pc), .busy(busy), .halted(halted), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: program ROM, register file and the shared incrementer.
    assign imem_data = imem[imem_addr];
    assign reg_rdata = regs[reg_sel];
    assign inc_sum   = inc_a + W'(1);
    assign inc_carry = &inc_a;

    always @(posedge clk) begin
        if (reg_we) regs[reg_sel] <= reg_wdata;
        else if (reset) for (int i = 0; i < N; i++) regs[i] <= init_regs[i];
    end

    function automatic int probe(int code);
        case (code)
            0: return int'(pc);
            1: return int'(busy);
            2: return int'(halted);
            3: return int'(overflow);
            4: return int'(reg_we);
            5: return int'(inc_en);
            6: return int'(inc_a);
            7: return int'(reg_wdata);
            8: return int'(imem_addr);
            9: return int'(reg_sel);
            20: return wq.size() + pq.size() + oq.size() + hq.size();
            default: return int'(regs[(code - 10) % N]);
        endcase
    endfunction

    function automatic string pname(int code);
        case (code)
            0: return "pc";
            1: return "busy";
            2: return "halted";
            3: return "overflow";
            4: return "reg_we";
            5: return "inc_en";
            6: return "inc_a";
            7: return "reg_wdata";
            8: return "imem_addr";
            9: return "reg_sel";
            20: return "leftover_events";
            default: return "reg_file";
        endcase
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: pops expected events as the DUT presents them, plus queued spot checks.
    always @(negedge clk) begin
        ev_t   e;
        dchk_t d;
        if (mon_en) begin
            if (reg_we) begin
                chk("write_pending", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("write_sel", int'(reg_sel), e.a);
                    chk("write_data", int'(reg_wdata), e.b);
                    chk("write_cycle", cyc, e.cyc);
                end
            end
            if (pc != last_pc) begin
                chk("pc_pending", int'(pq.size() > 0), 1);
                if (pq.size() > 0) begin
                    e = pq.pop_front();
                    chk("pc_value", int'(pc), e.a);
                    chk("pc_cycle", cyc, e.cyc);
                end
            end
            if (overflow && !last_ovf) begin
                chk("ovf_pending", int'(oq.size() > 0), 1);
                if (oq.size() > 0) begin
                    e = oq.pop_front();
                    chk("ovf_cycle", cyc, e.cyc);
                end
            end
            if (halted && !last_halt) begin
                chk("halt_pending", int'(hq.size() > 0), 1);
                if (hq.size() > 0) begin
                    e = hq.pop_front();
                    chk("halt_cycle", cyc, e.cyc);
                end
            end
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            chk(pname(d.code), probe(d.code), d.exp);
        end
        last_pc   = pc;
        last_ovf  = overflow;
        last_halt = halted;
    end

    function automatic logic [W+1:0] enc(input int op, input int a);
        return {op[1:0], a[W-1:0]};
    endfunction

    task automatic expect_now(input int code, input int exp);
        dq.push_back(dchk_t'{code, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        tick(2);
        for (int c = 0; c <= 9; c++) expect_now(c, 0);
        reset = 1'b0;
    endtask

    task automatic pc_ev(input int c, input int v, input int lim, inout int pc_end);
        if (c < lim) pq.push_back(ev_t'{c, v, 0});
        if (c <= lim) pc_end = v;
    endtask

    // Reference: walks the program one instruction at a time from the ISA rules and
    // the per-instruction cycle counts, starting from FETCH at cycle t0.
    task automatic model(input int t0, input int b, output int pc_end, output int halt_end,
                         output int ovf_end);
        int t, p, ovf, lim, op, a, nv;
        int mr[N];
        bit wrap, done;
        t = t0; p = 0; ovf = 0; lim = t0 + b; done = 0;
        pc_end = 0; halt_end = 0; ovf_end = 0;
        for (int i = 0; i < N; i++) mr[i] = int'(init_regs[i]);
        while (!done && t < lim) begin
            op = int'(imem[p][W+1:W]);
            a  = int'(imem[p][W-1:0]);
            if (op <= 1) begin
                nv   = (op == 0) ? (mr[a] + 1) % N : (mr[a] + N - 1) % N;
                wrap = (op == 0) ? (mr[a] == N - 1) : (mr[a] == 0);
                if (t + 1 < lim) wq.push_back(ev_t'{t + 1, a, nv});
                if (wrap && ovf == 0) begin
                    ovf = 1;
                    if (t + 2 < lim) oq.push_back(ev_t'{t + 2, 0, 0});
                    if (t + 2 <= lim) ovf_end = 1;
                end
                mr[a] = nv;
                p = (p + 1) % N;
                pc_ev(t + 3, p, lim, pc_end);
                t += 3;
            end else if (op == 2) begin
                p = (p + 1) % N;
                pc_ev(t + 3, p, lim, pc_end);
                if (mr[a] == 0) begin
                    p = (p + 1) % N;
                    pc_ev(t + 4, p, lim, pc_end);
                    t += 4;
                end else begin
                    t += 3;
                end
            end else if (a == p) begin
                if (t + 2 < lim) hq.push_back(ev_t'{t + 2, 0, 0});
                if (t + 2 <= lim) halt_end = 1;
                done = 1;
            end else begin
                p = a;
                pc_ev(t + 2, p, lim, pc_end);
                t += 2;
            end
        end
    endtask

    task automatic run_segment(input int b);
        int t0, pe, he, oe;
        do_reset();
        t0 = cyc + 1;
        model(t0, b, pe, he, oe);
        mon_en = 1'b1;
        run    = 1'b1;
        while (cyc < t0 + b) tick(1);
        mon_en = 1'b0;
        expect_now(0, pe);
        expect_now(1, he ? 0 : 1);
        expect_now(2, he);
        expect_now(3, oe);
        expect_now(20, 0);
        reset = 1'b1;
        run   = 1'b0;
    endtask

    task automatic set_prog(input logic [W+1:0] i0, input logic [W+1:0] i1,
                            input logic [W+1:0] i2, input logic [W+1:0] i3);
        imem[0] = i0; imem[1] = i1; imem[2] = i2; imem[3] = i3;
    endtask

    task automatic set_regs(input int r0, input int r1, input int r2, input int r3);
        init_regs[0] = W'(r0); init_regs[1] = W'(r1);
        init_regs[2] = W'(r2); init_regs[3] = W'(r3);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < N; i++) begin
            imem[i] = '0;
            init_regs[i] = '0;
        end
        tick(1);
`ifndef SINGLE_STEP_EN
        // Directed programs through the reference model.
        set_prog(enc(0, 1), enc(2, 0), enc(0, 0), enc(3, 3)); set_regs(1, 3, 0, 0);
        run_segment(6);
        set_prog(enc(1, 0), enc(0, 2), enc(3, 2), enc(0, 0)); set_regs(0, 1, 1, 1);
        run_segment(6);
        set_prog(enc(1, 0), enc(0, 2), enc(3, 2), enc(0, 0)); set_regs(2, 1, 1, 1);
        run_segment(6);
        set_prog(enc(0, 3), enc(2, 2), enc(0, 0), enc(3, 3)); set_regs(1, 1, 0, 1);
        run_segment(12);
        set_prog(enc(0, 3), enc(2, 2), enc(0, 0), enc(3, 3)); set_regs(1, 1, 1, 1);
        run_segment(12);
        set_prog(enc(3, 2), enc(0, 0), enc(0, 0), enc(3, 3)); set_regs(0, 0, 0, 0);
        run_segment(30);
        set_prog(enc(3, 3), enc(0, 1), enc(0, 1), enc(0, 0)); set_regs(0, 0, 0, 0);
        run_segment(8);

        // Random programs and register contents.
        for (int s = 0; s < 25; s++) begin
            for (int i = 0; i < N; i++) begin
                imem[i]      = (W + 2)'($urandom);
                init_regs[i] = W'($urandom);
            end
            run_segment(40);
        end

        // Dropping run during EXEC still completes the instruction, then idles.
        set_prog(enc(0, 2), enc(0, 2), enc(0, 2), enc(0, 2)); set_regs(0, 0, 1, 0);
        do_reset();
        t0 = cyc + 1;
        run = 1'b1;
        while (cyc < t0 + 1) tick(1);
        run = 1'b0;
        tick(6);
        expect_now(0, 1);
        expect_now(1, 0);
        expect_now(5, 0);
        expect_now(12, 2);

        // Reset during EXEC of the second instruction: no write, no overflow, pc back to 0.
        set_prog(enc(0, 0), enc(0, 1), enc(0, 1), enc(0, 1)); set_regs(0, 3, 0, 0);
        do_reset();
        t0 = cyc + 1;
        run = 1'b1;
        while (cyc < t0 + 4) tick(1);
        reset = 1'b1;
        run   = 1'b0;
        expect_now(4, 0);
        tick(1);
        reset = 1'b0;
        expect_now(0, 0);
        expect_now(1, 0);
        expect_now(3, 0);
        expect_now(11, 3);
        tick(2);
`else
        // Three step pulses execute exactly three instructions.
        set_prog(enc(0, 0), enc(0, 0), enc(0, 0), enc(0, 0)); set_regs(0, 0, 0, 0);
        do_reset();
        run = 1'b1;
        tick(5);
        expect_now(0, 0);
        expect_now(1, 0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(6);
        end
        expect_now(10, 3);
        expect_now(0, 3);
        expect_now(1, 0);
        tick(2);
`endif
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
